// File: rtl/clock_freq_meter_if.sv
// Bus bundle for clock_freq_meter.
// master (testbench/consumer): drives enable and meas_clk, observes results.
// slave  (meter):              samples enable/meas_clk, drives all results.
//   enable        measurement enable, synchronous to clk
//   meas_clk      clock under test, asynchronous to clk
//   edge_count    rising edges counted in the last completed window
//   count_valid   one-cycle pulse when edge_count updates
//   overflow      last completed window saturated
//   period        clk cycles between the last two meas_clk rises
//   period_valid  one-cycle pulse when period updates
//   stalled       no meas_clk rise for 2^PER_W-1 cycles
interface clock_freq_meter_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PER_W = 16
);
    logic             enable;
    logic             meas_clk;
    logic [CNT_W-1:0] edge_count;
    logic             count_valid;
    logic             overflow;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;

    modport master (
        output enable, meas_clk,
        input  edge_count, count_valid, overflow, period, period_valid, stalled
    );

    modport slave (
        input  enable, meas_clk,
        output edge_count, count_valid, overflow, period, period_valid, stalled
    );
endinterface

// File: rtl/clock_freq_meter.sv
// Measures an asynchronous clock against clk: counts meas_clk rising edges
// over a GATE_CYCLES window and reports the rise-to-rise period in clk cycles.
// Ports:
//   clk     system clock, all logic on posedge
//   resetn  asynchronous active-low reset
//   bus     clock_freq_meter_if.slave (enable, meas_clk in; results out)
module clock_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned PER_W       = 16
) (
    input  logic                clk,
    input  logic                resetn,
    clock_freq_meter_if.slave   bus
);
    localparam int unsigned     GCNT_W    = $clog2(GATE_CYCLES);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  ACC_MAX   = '1;
    localparam logic [PER_W-1:0]  PCNT_MAX  = '1;

    // Synchronizer and rise detect; runs regardless of enable
    logic r_s1, r_s2, r_s3;
    logic w_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.meas_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Gate window state
    logic [GCNT_W-1:0] r_gcnt;
    logic [CNT_W-1:0]  r_acc;
    logic              r_acc_ovf;
    logic [CNT_W-1:0]  r_edge_count;
    logic              r_count_valid;
    logic              r_overflow;
    logic [CNT_W-1:0]  w_acc_next;
    logic              w_acc_ovf_next;

    // Saturating accumulate; overflow flags a rise lost at full scale
    always_comb begin
        w_acc_next     = r_acc;
        w_acc_ovf_next = r_acc_ovf;
        if (w_rise) begin
            if (r_acc == ACC_MAX) begin
                w_acc_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + CNT_W'(1);
            end
        end
    end

    // Window counter; the terminal cycle's rise lands in the closing window
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_gcnt        <= '0;
            r_acc         <= '0;
            r_acc_ovf     <= 1'b0;
            r_edge_count  <= '0;
            r_count_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count_valid <= 1'b0;
            if (!bus.enable) begin
                r_gcnt    <= '0;
                r_acc     <= '0;
                r_acc_ovf <= 1'b0;
            end else if (r_gcnt == GCNT_LAST) begin
                r_edge_count  <= w_acc_next;
                r_overflow    <= w_acc_ovf_next;
                r_count_valid <= 1'b1;
                r_gcnt        <= '0;
                r_acc         <= '0;
                r_acc_ovf     <= 1'b0;
            end else begin
                r_gcnt    <= r_gcnt + GCNT_W'(1);
                r_acc     <= w_acc_next;
                r_acc_ovf <= w_acc_ovf_next;
            end
        end
    end

    // Period measurement and stall detect
    logic [PER_W-1:0] r_pcnt;
    logic             r_armed;
    logic [PER_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_stalled;

    // pcnt restarts at 1 on a rise so rises N cycles apart report N
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pcnt         <= '0;
            r_armed        <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (!bus.enable) begin
                r_pcnt  <= '0;
                r_armed <= 1'b0;
            end else if (w_rise) begin
                if (r_armed) begin
                    r_period       <= r_pcnt;
                    r_period_valid <= 1'b1;
                end
                r_pcnt    <= PER_W'(1);
                r_armed   <= 1'b1;
                r_stalled <= 1'b0;
            end else if (r_pcnt == PCNT_MAX) begin
                r_stalled <= 1'b1;
                r_armed   <= 1'b0;
            end else begin
                r_pcnt <= r_pcnt + PER_W'(1);
            end
        end
    end

    assign bus.edge_count   = r_edge_count;
    assign bus.count_valid  = r_count_valid;
    assign bus.overflow     = r_overflow;
    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.stalled      = r_stalled;

endmodule
